// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding, port IDs and
// default bus widths used by the arbiter, ramctlr and the UART loader.
package ram_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational two-way chooser: picks the single requester, or on a tie
// either the port not served last (round-robin) or port A (fixed priority).
module rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last,
  input  logic  rr_en,
  output logic  grant_valid,
  output port_t grant_id
);

  // Grant decision; A is the default winner unless round-robin says B's turn
  always_comb begin
    grant_valid = req_a | req_b;
    grant_id    = PORT_A;
    if (req_a && req_b) begin
      if (rr_en && (last == PORT_A)) grant_id = PORT_B;
    end else if (req_b) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing the single ramctlr link between the core data port
// (A) and the UART loader (B). One word transaction at a time, with a bounded
// wait for m_ack after which the transaction is aborted with err.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RR      = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              b_err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  // Counter value on the last BUSY cycle; m_req is held for TIMEOUT cycles
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t              state, state_nxt;
  port_t               gnt, gnt_nxt;
  port_t               last_grant, last_nxt;
  logic [15:0]         cnt, cnt_nxt;
  logic                mreq_nxt, mwe_nxt;
  logic [ADDR_W-1:0]   maddr_nxt;
  logic [DATA_W-1:0]   mwdata_nxt;
  logic                a_ack_nxt, a_err_nxt, b_ack_nxt, b_err_nxt;
  logic [DATA_W-1:0]   a_rdata_nxt, b_rdata_nxt;
  logic                done, fail;
  logic [DATA_W-1:0]   rdata_v;
  logic                grant_valid;
  port_t               grant_id;

  rr_pick u_pick (
    .req_a       (a_req),
    .req_b       (b_req),
    .last        (last_grant),
    .rr_en       (RR != 0),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state, timeout and registered-output computation
  always_comb begin
    state_nxt  = state;
    gnt_nxt    = gnt;
    last_nxt   = last_grant;
    cnt_nxt    = cnt;
    mreq_nxt   = m_req;
    mwe_nxt    = m_we;
    maddr_nxt  = m_addr;
    mwdata_nxt = m_wdata;
    done       = 1'b0;
    fail       = 1'b0;
    rdata_v    = '0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_nxt  = BUSY;
          gnt_nxt    = grant_id;
          last_nxt   = grant_id;
          cnt_nxt    = '0;
          mreq_nxt   = 1'b1;
          mwe_nxt    = (grant_id == PORT_A) ? a_we    : b_we;
          maddr_nxt  = (grant_id == PORT_A) ? a_addr  : b_addr;
          mwdata_nxt = (grant_id == PORT_A) ? a_wdata : b_wdata;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + 16'd1;
        // A late m_ack on the final cycle still wins over the abort
        if (m_ack) begin
          done    = 1'b1;
          rdata_v = m_rdata;
        end else if (cnt == TO_LAST) begin
          done = 1'b1;
          fail = 1'b1;
        end
        if (done) begin
          mreq_nxt  = 1'b0;
          state_nxt = RESP;
        end
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    a_ack_nxt   = done && (gnt == PORT_A);
    a_err_nxt   = done && fail && (gnt == PORT_A);
    a_rdata_nxt = (done && (gnt == PORT_A)) ? rdata_v : '0;
    b_ack_nxt   = done && (gnt == PORT_B);
    b_err_nxt   = done && fail && (gnt == PORT_B);
    b_rdata_nxt = (done && (gnt == PORT_B)) ? rdata_v : '0;
  end

  // State, counter and every output registered; reset abandons any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= PORT_A;
      last_grant <= PORT_B;
      cnt        <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      a_ack      <= 1'b0;
      a_err      <= 1'b0;
      a_rdata    <= '0;
      b_ack      <= 1'b0;
      b_err      <= 1'b0;
      b_rdata    <= '0;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
      m_req      <= mreq_nxt;
      m_we       <= mwe_nxt;
      m_addr     <= maddr_nxt;
      m_wdata    <= mwdata_nxt;
      a_ack      <= a_ack_nxt;
      a_err      <= a_err_nxt;
      a_rdata    <= a_rdata_nxt;
      b_ack      <= b_ack_nxt;
      b_err      <= b_err_nxt;
      b_rdata    <= b_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin instance (TIMEOUT=8) driven by directed
// and random requesters against a memory responder, plus a fixed-priority
// instance for the priority scenario.
module tb_ram_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata;
  logic        a_ack, a_err;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [31:0] b_rdata;
  logic        b_ack, b_err;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;

  logic        f_a_req = 1'b0, f_a_we = 1'b0;
  logic [31:0] f_a_addr = '0, f_a_wdata = '0;
  logic [31:0] f_a_rdata;
  logic        f_a_ack, f_a_err;
  logic        f_b_req = 1'b0, f_b_we = 1'b0;
  logic [31:0] f_b_addr = '0, f_b_wdata = '0;
  logic [31:0] f_b_rdata;
  logic        f_b_ack, f_b_err;
  logic        f_m_req, f_m_we;
  logic [31:0] f_m_addr, f_m_wdata;
  logic [31:0] f_m_rdata = '0;
  logic        f_m_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          tout;
  } rec_t;
  rec_t rec_q[$];

  int slv_lat  = 1;
  bit slv_rand = 1'b0;
  bit spur     = 1'b0;

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  ram_arbiter #(.ADDR_W(32), .DATA_W(32), .RR(0), .TIMEOUT(TO)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(f_a_req), .a_we(f_a_we), .a_addr(f_a_addr), .a_wdata(f_a_wdata),
    .a_rdata(f_a_rdata), .a_ack(f_a_ack), .a_err(f_a_err),
    .b_req(f_b_req), .b_we(f_b_we), .b_addr(f_b_addr), .b_wdata(f_b_wdata),
    .b_rdata(f_b_rdata), .b_ack(f_b_ack), .b_err(f_b_err),
    .m_req(f_m_req), .m_we(f_m_we), .m_addr(f_m_addr), .m_wdata(f_m_wdata),
    .m_rdata(f_m_rdata), .m_ack(f_m_ack)
  );

  // Memory contents seen by both instances: fixed per address
  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Responder for the round-robin instance; logs each transaction it sees
  task automatic slave_loop();
    int          cnt_s = 0;
    int          lat   = 0;
    logic [64:0] held  = '0;
    forever begin
      @(negedge clk);
      if (m_req && !rst) begin
        cnt_s++;
        if (cnt_s == 1) begin
          lat = slv_rand ? int'($urandom_range(0, 9)) : slv_lat;
          rec_q.push_back('{m_we, m_addr, m_wdata, (lat == 0 || lat > TO)});
          held = {m_we, m_addr, m_wdata};
        end else begin
          checks++;
          if ({m_we, m_addr, m_wdata} !== held) begin
            errors++;
            $display("FAIL m_hold got %h want %h", {m_we, m_addr, m_wdata}, held);
          end
        end
        m_ack   = (cnt_s == lat);
        m_rdata = m_ack ? rom(m_addr) : 32'hA5A5A5A5;
      end else begin
        cnt_s   = 0;
        m_ack   = spur;
        m_rdata = 32'hA5A5A5A5;
      end
    end
  endtask

  // Single-cycle-latency responder for the fixed-priority instance
  task automatic slave_fp();
    forever begin
      @(negedge clk);
      f_m_ack   = f_m_req;
      f_m_rdata = f_m_req ? rom(f_m_addr) : 32'hA5A5A5A5;
    end
  endtask

  // Issue one transaction on A or B and report the cycle of its ack
  task automatic run_txn(input bit is_b, input logic we, input logic [31:0] ad,
                         input logic [31:0] wd, output int cyc, output logic err,
                         output logic [31:0] rd);
    @(negedge clk);
    if (is_b) begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
    else      begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
    cyc = -1; err = 1'b0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (is_b ? b_ack : a_ack) begin
        cyc = c;
        err = is_b ? b_err : a_err;
        rd  = is_b ? b_rdata : a_rdata;
        break;
      end
    end
    if (is_b) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, m_req, m_we, m_addr, m_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, m_req, m_we, m_addr, m_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic        exp_mreq, exp_ack;
    slv_lat = 3;
    @(negedge clk);
    a_we = 1'b0; a_addr = 32'h10; a_wdata = $urandom; a_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_mreq = (c <= 3);
      exp_ack  = (c == 4);
      checks++;
      if (m_req !== exp_mreq) begin
        errors++;
        $display("FAIL read_mreq cycle %0d got %b want %b", c, m_req, exp_mreq);
      end
      checks++;
      if ({a_ack, a_err, a_rdata} !== {exp_ack, 1'b0, (exp_ack ? 32'hDEADBEEF : 32'h0)}) begin
        errors++;
        $display("FAIL read_ack cycle %0d got %b/%b/%h want %b/0/%h", c, a_ack, a_err,
                 a_rdata, exp_ack, (exp_ack ? 32'hDEADBEEF : 32'h0));
      end
      checks++;
      if (b_ack !== 1'b0) begin
        errors++;
        $display("FAIL read_b_ack cycle %0d got %b want 0", c, b_ack);
      end
      if (a_ack) a_req = 1'b0;
    end
    a_req = 1'b0;
  endtask

  task automatic test_timeout();
    logic        exp_mreq, exp_ack;
    int          cyc;
    logic        err;
    logic [31:0] rd;
    slv_lat = 0;
    @(negedge clk);
    b_we = 1'b1; b_addr = 32'h100; b_wdata = 32'h12345678; b_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_mreq = (c <= TO);
      exp_ack  = (c == TO + 1);
      checks++;
      if (m_req !== exp_mreq) begin
        errors++;
        $display("FAIL tout_mreq cycle %0d got %b want %b", c, m_req, exp_mreq);
      end
      if (exp_mreq) begin
        checks++;
        if ({m_we, m_addr, m_wdata} !== {1'b1, 32'h100, 32'h12345678}) begin
          errors++;
          $display("FAIL tout_mfields cycle %0d got %b/%h/%h want 1/100/12345678", c, m_we,
                   m_addr, m_wdata);
        end
      end
      checks++;
      if ({b_ack, b_err, b_rdata, a_ack} !== {exp_ack, exp_ack, 32'h0, 1'b0}) begin
        errors++;
        $display("FAIL tout_ack cycle %0d got %b/%b/%h a_ack %b want %b/%b/0 a_ack 0", c,
                 b_ack, b_err, b_rdata, a_ack, exp_ack, exp_ack);
      end
      if (b_ack) b_req = 1'b0;
    end
    b_req = 1'b0;
    slv_lat = 2;
    run_txn(1'b0, 1'b0, 32'h44, 32'h0, cyc, err, rd);
    checks++;
    if (cyc != 3 || err !== 1'b0 || rd !== rom(32'h44)) begin
      errors++;
      $display("FAIL after_tout got cyc %0d err %b rd %h want cyc 3 err 0 rd %h", cyc, err,
               rd, rom(32'h44));
    end
  endtask

  task automatic test_timeout_boundary();
    int          cyc;
    logic        err;
    logic [31:0] rd;
    logic [31:0] ad;
    ad = $urandom;
    slv_lat = TO;
    run_txn(1'b1, 1'b0, ad, 32'h0, cyc, err, rd);
    checks++;
    if (cyc != TO + 1 || err !== 1'b0 || rd !== rom(ad)) begin
      errors++;
      $display("FAIL ack_at_timeout got cyc %0d err %b rd %h want cyc %0d err 0 rd %h", cyc,
               err, rd, TO + 1, rom(ad));
    end
  endtask

  task automatic test_rr_tie();
    int order[$];
    int last_srv;
    int exp_p;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    slv_lat = 1;
    a_we = 1'b0; b_we = 1'b0; a_addr = 32'h200; b_addr = 32'h300;
    a_req = 1'b1; b_req = 1'b1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (a_ack) begin
        order.push_back(0);
        checks++;
        if (a_rdata !== rom(32'h200)) begin
          errors++;
          $display("FAIL rr_a_data got %h want %h", a_rdata, rom(32'h200));
        end
      end
      if (b_ack) begin
        order.push_back(1);
        checks++;
        if (b_rdata !== rom(32'h300)) begin
          errors++;
          $display("FAIL rr_b_data got %h want %h", b_rdata, rom(32'h300));
        end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL rr_count got %0d want 4", order.size());
    end else begin
      last_srv = 1;
      for (int i = 0; i < 4; i++) begin
        exp_p    = 1 - last_srv;
        last_srv = exp_p;
        checks++;
        if (order[i] != exp_p) begin
          errors++;
          $display("FAIL rr_order idx %0d got %0d want %0d", i, order[i], exp_p);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    int  first;
    bit  a_done, b_done;
    slv_lat = 0;
    @(negedge clk);
    a_we = 1'b0; a_addr = 32'h80; a_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (m_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_mreq got %b want 1", m_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_req, a_ack, b_ack} !== 3'b000) begin
      errors++;
      $display("FAIL rst_async got m_req/a_ack/b_ack %b want 000", {m_req, a_ack, b_ack});
    end
    @(negedge clk);
    a_req = 1'b0;
    rst   = 1'b0;
    slv_lat = 1;
    @(negedge clk);
    a_addr = 32'h84; b_we = 1'b0; b_addr = 32'h88; a_req = 1'b1; b_req = 1'b1;
    first = -1; a_done = 1'b0; b_done = 1'b0;
    for (int c = 0; c < 40 && !(a_done && b_done); c++) begin
      @(negedge clk);
      if (a_ack) begin if (first < 0) first = 0; a_done = 1'b1; a_req = 1'b0; end
      if (b_ack) begin if (first < 0) first = 1; b_done = 1'b1; b_req = 1'b0; end
    end
    a_req = 1'b0; b_req = 1'b0;
    checks++;
    if (first != 0 || !b_done) begin
      errors++;
      $display("FAIL rst_tie got first %0d b_done %b want first 0 b_done 1", first, b_done);
    end
  endtask

  task automatic test_spurious_ack();
    int          cyc;
    logic        err;
    logic [31:0] rd;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({a_ack, b_ack, m_req} !== 3'b000) begin
        errors++;
        $display("FAIL spur_idle got a_ack/b_ack/m_req %b want 000", {a_ack, b_ack, m_req});
      end
    end
    slv_lat = 2;
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, cyc, err, rd);
    checks++;
    if (cyc != 3 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL spur_then_read got cyc %0d err %b rd %h want cyc 3 err 0 rd deadbeef",
               cyc, err, rd);
    end
  endtask

  task automatic test_fixed_priority();
    int order[$];
    int a_cnt;
    int exp_o[4];
    exp_o[0] = 0; exp_o[1] = 0; exp_o[2] = 0; exp_o[3] = 1;
    a_cnt = 0;
    @(negedge clk);
    f_a_addr = 32'h40; f_b_addr = 32'h50; f_a_req = 1'b1; f_b_req = 1'b1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (f_a_ack) begin
        order.push_back(0);
        a_cnt++;
        checks++;
        if (f_a_rdata !== rom(32'h40)) begin
          errors++;
          $display("FAIL fp_a_data got %h want %h", f_a_rdata, rom(32'h40));
        end
        if (a_cnt == 3) f_a_req = 1'b0;
      end
      if (f_b_ack) begin
        order.push_back(1);
        f_b_req = 1'b0;
      end
    end
    f_a_req = 1'b0; f_b_req = 1'b0;
    checks++;
    if (order.size() != 4) begin
      errors++;
      $display("FAIL fp_count got %0d want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (order[i] != exp_o[i]) begin
          errors++;
          $display("FAIL fp_order idx %0d got %0d want %0d", i, order[i], exp_o[i]);
        end
      end
    end
  endtask

  // Randomised requester: each completed ack must match the logged transaction
  task automatic requester(input bit is_b, input int n);
    logic [31:0] ad, wd, rd;
    logic        we, ack_o, err;
    rec_t        r;
    bit          got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      ad = $urandom; wd = $urandom; we = 1'($urandom_range(0, 1));
      if (is_b) begin b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1; end
      else      begin a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1; end
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
        @(negedge clk);
        got = is_b ? b_ack : a_ack;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL rnd_no_ack port %0d txn %0d got none want ack", is_b, i);
      end else if (rec_q.size() == 0) begin
        errors++;
        $display("FAIL rnd_no_record port %0d got 0 records want 1", is_b);
      end else begin
        r     = rec_q.pop_front();
        err   = is_b ? b_err : a_err;
        rd    = is_b ? b_rdata : a_rdata;
        ack_o = is_b ? a_ack : b_ack;
        if ({r.we, r.addr, r.wdata} !== {we, ad, wd}) begin
          errors++;
          $display("FAIL rnd_fields port %0d got %b/%h/%h want %b/%h/%h", is_b, r.we, r.addr,
                   r.wdata, we, ad, wd);
        end
        checks++;
        if (err !== logic'(r.tout) || rd !== (r.tout ? 32'h0 : rom(ad)) || ack_o !== 1'b0) begin
          errors++;
          $display("FAIL rnd_resp port %0d got err %b rd %h other %b want err %b rd %h other 0",
                   is_b, err, rd, ack_o, r.tout, (r.tout ? 32'h0 : rom(ad)));
        end
      end
      if (is_b) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    rec_q.delete();
    slv_rand = 1'b1;
    fork
      requester(1'b0, 20);
      requester(1'b1, 20);
    join
    slv_rand = 1'b0;
  endtask

  initial begin
    fork
      slave_loop();
      slave_fp();
    join_none
    test_reset();
    test_single_read();
    test_timeout();
    test_timeout_boundary();
    test_rr_tie();
    test_reset_mid_busy();
    test_spurious_ack();
    test_fixed_priority();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
